// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified instruction/data memory between fetch and load/store.
// Data has priority; a burst limit forces a fetch grant after MAX_DATA_BURST data grants.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT        = 2,
  parameter int unsigned MAX_DATA_BURST = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned BW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(MEM_LAT - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_n;
  logic [LW-1:0] lat_cnt;
  logic [BW-1:0] burst;
  logic          owner_d;
  logic          flush_pend;
  logic          fetch_ok, grant_d, grant_f, misalign, last;

  always_comb begin
    fetch_ok = if_req && !if_flush;
    grant_d  = d_req && !(fetch_ok && (burst == BURST_MAX));
    grant_f  = !grant_d && fetch_ok;
    misalign = ((d_size == 2'b01) && d_addr[0]) ||
               ((d_size == 2'b10) && (d_addr[1:0] != 2'b00));
    last     = (lat_cnt == LAT_LAST);
    state_n  = state;
    case (state)
      IDLE:    if (grant_d && misalign)  state_n = RESP;
               else if (grant_d || grant_f) state_n = ACCESS;
      ACCESS:  if (last) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if_ready   <= 1'b0;
      if_rdata   <= '0;
      d_ready    <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_size   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      lat_cnt    <= '0;
      burst      <= '0;
      owner_d    <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      d_err    <= 1'b0;
      case (state)
        IDLE: begin
          flush_pend <= 1'b0;
          lat_cnt    <= '0;
          if (grant_d) begin
            owner_d <= 1'b1;
            if (!if_req)                 burst <= '0;
            else if (burst != BURST_MAX) burst <= burst + BW'(1);
            // Misaligned requests answer from here without touching memory.
            if (misalign) begin
              d_ready <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end else begin
              mem_en    <= 1'b1;
              mem_we    <= d_we;
              mem_size  <= d_size;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end
          end else if (grant_f) begin
            owner_d   <= 1'b0;
            burst     <= '0;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_size  <= 2'b10;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end
        end
        ACCESS: begin
          lat_cnt <= lat_cnt + LW'(1);
          if (!owner_d && if_flush) flush_pend <= 1'b1;
          if (last) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (owner_d) begin
              d_ready <= 1'b1;
              d_rdata <= mem_we ? '0 : mem_rdata;
            end else if (!(flush_pend || if_flush)) begin
              if_ready <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          if (!owner_d && if_flush) flush_pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences, and a
// random run checked against a transaction-schedule reference model.
module tb_mem_port_arbiter;

  localparam int L    = 2;
  localparam int MAXB = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0, if_ready;
  logic [31:0] if_addr = '0, if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_ready, d_err;
  logic [1:0]  d_size = '0;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic        mem_en, mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] ov_addr = 32'hFFFF_FFFF;
  logic [31:0] ov_val  = '0;
  int          en_cnt  = 0;

  mem_port_arbiter #(.MEM_LAT(L), .MAX_DATA_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hashf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a == ov_addr) ? ov_val : hashf(a);
  endfunction

  // Memory data is only valid in the last cycle of an access.
  always @(posedge clk) en_cnt <= mem_en ? en_cnt + 1 : 0;
  assign mem_rdata = (mem_en && en_cnt == L - 1) ?
                     ((mem_addr == ov_addr) ? ov_val : hashf(mem_addr)) : 32'hBAD0_BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        fetch;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memval;
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v);
    int k, en_n;
    ov_addr = v.addr;
    ov_val  = v.memval;
    if (v.fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      d_req = 1'b1; d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
    end
    k = 0; en_n = 0;
    while (k < 20) begin
      tick(); k++;
      if (mem_en) begin
        en_n++;
        chk("vec_mem_addr", mem_addr, v.addr);
        chk("vec_mem_we", {31'b0, mem_we}, {31'b0, !v.fetch && v.we});
        chk("vec_mem_size", {30'b0, mem_size}, {30'b0, v.fetch ? 2'b10 : v.size});
        if (!v.fetch && v.we) chk("vec_mem_wdata", mem_wdata, v.wdata);
      end
      if (if_ready || d_ready) break;
    end
    chk("vec_latency", k, v.lat);
    chk("vec_en_cycles", en_n, v.err ? 0 : L);
    chk("vec_if_ready", {31'b0, if_ready}, {31'b0, v.fetch});
    chk("vec_d_ready", {31'b0, d_ready}, {31'b0, !v.fetch});
    if (v.fetch) chk("vec_if_rdata", if_rdata, v.rdata);
    else begin
      chk("vec_d_rdata", d_rdata, v.rdata);
      chk("vec_d_err", {31'b0, d_err}, {31'b0, v.err});
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dk, fk, fen, n, cnt;
    logic we1;
    logic [31:0] drd, frd, prev;
    int got[8];
    // random-phase model state
    bit busy, t_data, t_mis, t_we, t_supp, done_d, done_f, fresp, e_en, e_dr, e_ir, gd, gf, fok;
    int g, resp_c, burst_m;
    logic [1:0] t_size;
    logic [31:0] t_addr, t_wdata, exp_ifr;

    vecs[0] = '{1'b1, 1'b0, 2'b10, 32'h10,  32'h0,        32'h00500093, L+1, 1'b0, 32'h00500093};
    vecs[1] = '{1'b0, 1'b0, 2'b10, 32'h200, 32'h0,        32'h11223344, L+1, 1'b0, 32'h11223344};
    vecs[2] = '{1'b0, 1'b0, 2'b01, 32'h202, 32'h0,        32'hCAFE0001, L+1, 1'b0, 32'hCAFE0001};
    vecs[3] = '{1'b0, 1'b0, 2'b00, 32'h203, 32'h0,        32'h000000AB, L+1, 1'b0, 32'h000000AB};
    vecs[4] = '{1'b0, 1'b1, 2'b10, 32'h104, 32'hDEADBEEF, 32'h77777777, L+1, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 2'b00, 32'h33,  32'h55,       32'h12345678, L+1, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 2'b01, 32'h201, 32'h0,        32'h99999999, 1,   1'b1, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 2'b10, 32'h102, 32'h0,        32'h88888888, 1,   1'b1, 32'h0};
    vecs[8] = '{1'b0, 1'b1, 2'b10, 32'h301, 32'hFFFF0000, 32'h66666666, 1,   1'b1, 32'h0};
    vecs[9] = '{1'b1, 1'b0, 2'b10, 32'h44,  32'h0,        32'h00000013, L+1, 1'b0, 32'h00000013};

    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_if_ready", {31'b0, if_ready}, 0);
    chk("rst_d_ready", {31'b0, d_ready}, 0);
    chk("rst_d_err", {31'b0, d_err}, 0);
    chk("rst_mem_en", {31'b0, mem_en}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_mem_size", {30'b0, mem_size}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Store and fetch together: data first, fetch granted right after RESP.
    ov_addr = 32'h80; ov_val = 32'h00A00113;
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h104; d_wdata = 32'hDEADBEEF;
    if_req = 1'b1; if_addr = 32'h80;
    dk = 0; fk = 0; fen = 0; we1 = 1'b0; drd = 32'hFFFF_FFFF; frd = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) we1 = mem_we;
      if (mem_en && !mem_we && fen == 0) fen = k;
      if (d_ready && dk == 0) begin dk = k; drd = d_rdata; d_req = 1'b0; d_we = 1'b0; end
      if (if_ready && fk == 0) begin fk = k; frd = if_rdata; if_req = 1'b0; end
    end
    chk("pri_store_we", {31'b0, we1}, 1);
    chk("pri_d_ready_cycle", dk, L + 1);
    chk("pri_store_rdata", drd, 0);
    chk("pri_fetch_en_cycle", fen, L + 3);
    chk("pri_if_ready_cycle", fk, 2 * L + 3);
    chk("pri_if_rdata", frd, 32'h00A00113);

    // Burst limit with both requesters held high.
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h400;
    if_req = 1'b1; if_addr = 32'h500;
    n = 0;
    for (int i = 0; i < 8; i++) got[i] = 2;
    for (int k = 0; k < 100 && n < 8; k++) begin
      tick();
      if (d_ready) begin got[n] = 1; n++; end
      else if (if_ready) begin got[n] = 0; n++; end
    end
    chk("burst_count", n, 8);
    for (int i = 0; i < 8; i++) chk("burst_seq", got[i], (i % 4 == 3) ? 0 : 1);
    d_req = 1'b0; if_req = 1'b0;
    repeat (L + 3) tick();

    // Reset in the middle of a load.
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h600;
    tick();
    chk("rstmid_en_before", {31'b0, mem_en}, 1);
    rst = 1'b0; d_req = 1'b0;
    tick();
    chk("rstmid_en_after", {31'b0, mem_en}, 0);
    chk("rstmid_d_ready", {31'b0, d_ready}, 0);
    rst = 1'b1;
    cnt = 0;
    repeat (5) begin tick(); if (d_ready) cnt++; end
    chk("rstmid_no_ready", cnt, 0);
    run_vec(vecs[1]);

    // Flush during a fetch access.
    ov_addr = 32'h900; ov_val = 32'h00000297;
    prev = if_rdata;
    if_req = 1'b1; if_addr = 32'h800;
    fk = 0; frd = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == L + 1) begin
        chk("flush_ready_suppressed", {31'b0, if_ready}, 0);
        chk("flush_rdata_hold", if_rdata, prev);
      end
      if (if_ready && fk == 0) begin fk = k; frd = if_rdata; if_req = 1'b0; end
      if (k == 1) begin if_flush = 1'b1; if_addr = 32'h900; end
      else if_flush = 1'b0;
    end
    chk("flush_refetch_cycle", fk, 2 * L + 3);
    chk("flush_refetch_rdata", frd, 32'h00000297);

    // Random traffic against the schedule model.
    ov_addr = 32'hFFFF_FFFF;
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; if_flush = 1'b0;
    tick();
    rst = 1'b1;
    busy = 0; t_data = 0; t_mis = 0; t_we = 0; t_supp = 0; g = 0; burst_m = 0;
    t_size = '0; t_addr = '0; t_wdata = '0; exp_ifr = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      resp_c = g + (t_mis ? 1 : L + 1);
      e_en = busy && !t_mis && c >= g + 1 && c <= g + L;
      e_dr = busy && t_data && c == resp_c;
      e_ir = busy && !t_data && c == resp_c && !t_supp;
      chk("rnd_mem_en", {31'b0, mem_en}, {31'b0, e_en});
      chk("rnd_d_ready", {31'b0, d_ready}, {31'b0, e_dr});
      chk("rnd_if_ready", {31'b0, if_ready}, {31'b0, e_ir});
      if (e_en) begin
        chk("rnd_mem_addr", mem_addr, t_addr);
        chk("rnd_mem_we", {31'b0, mem_we}, {31'b0, t_data && t_we});
        chk("rnd_mem_size", {30'b0, mem_size}, {30'b0, t_data ? t_size : 2'b10});
        if (t_data && t_we) chk("rnd_mem_wdata", mem_wdata, t_wdata);
      end
      if (e_dr) begin
        chk("rnd_d_rdata", d_rdata, (t_we || t_mis) ? 32'h0 : memfn(t_addr));
        chk("rnd_d_err", {31'b0, d_err}, {31'b0, t_mis});
      end
      if (e_ir) exp_ifr = memfn(t_addr);
      chk("rnd_if_rdata", if_rdata, exp_ifr);

      done_d = e_dr;
      done_f = e_ir;
      fresp  = busy && !t_data && c == resp_c;
      if_flush = 1'b0;
      if (done_f) begin
        if_req = ($urandom_range(9) < 7); if_addr = $urandom() & 32'h0000_FFFC;
      end else if (!if_req) begin
        if ($urandom_range(9) < 3) begin if_req = 1'b1; if_addr = $urandom() & 32'h0000_FFFC; end
      end else if (!fresp && $urandom_range(19) == 0) begin
        if_flush = 1'b1; if_addr = $urandom() & 32'h0000_FFFC;
      end
      if (done_d || !d_req) begin
        if (done_d ? ($urandom_range(9) < 7) : ($urandom_range(9) < 3)) begin
          d_req = 1'b1; d_we = $urandom_range(1); d_size = 2'($urandom_range(2));
          d_addr = $urandom() & 32'h0000_FFFF;
          if ($urandom_range(1) == 0) d_addr[1:0] = 2'b00;
          d_wdata = $urandom();
        end else d_req = 1'b0;
      end

      if (busy && !t_data && c >= g + 1 && c <= g + L && if_flush) t_supp = 1;
      if (!busy || c > resp_c) begin
        busy = 0;
        fok = if_req && !if_flush;
        gd  = d_req && !(fok && burst_m == MAXB);
        gf  = !gd && fok;
        if (gd) begin
          burst_m = if_req ? ((burst_m < MAXB) ? burst_m + 1 : MAXB) : 0;
          busy = 1; g = c; t_supp = 0; t_data = 1; t_we = d_we; t_size = d_size;
          t_addr = d_addr; t_wdata = d_wdata;
          t_mis = (d_size == 2'b01 && (d_addr % 2) != 0) || (d_size == 2'b10 && (d_addr % 4) != 0);
        end else if (gf) begin
          burst_m = 0;
          busy = 1; g = c; t_supp = 0; t_data = 0; t_we = 0; t_mis = 0;
          t_size = 2'b10; t_addr = if_addr; t_wdata = '0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
